store_buffer: RTL
=================

Name: store_buffer

Overview:
- Posted-write buffer between the CPU MEM stage and the data memory.
- Accepts doubleword stores in one cycle and drains them in order to memory over a valid/ready handshake.
- Forwards the youngest matching pending store to same-stage loads.
- Provides a fence for ordering. Decouples store latency from pipeline progress.

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.
- ADDR_W, 32, byte address width.
- DATA_W, 64, store/load data width.
- CNT_W, 32, width of the forward-hit statistics counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- st_valid  in  1  MEM stage presents a store.
- st_addr  in  ADDR_W  store byte address.
- st_data  in  DATA_W  store data.
- st_ready  out  1  buffer accepts the store this cycle.
- ld_valid  in  1  MEM stage presents a load.
- ld_addr  in  ADDR_W  load byte address.
- ld_hit  out  1  load matched a pending store.
- ld_data  out  DATA_W  forwarded data; 0 when ld_hit=0.
- mem_wr_valid  out  1  head entry is offered to data memory.
- mem_wr_addr  out  ADDR_W  head entry address.
- mem_wr_data  out  DATA_W  head entry data.
- mem_wr_ready  in  1  data memory accepts the head entry.
- fence_req  in  1  level request to drain all pending stores.
- fence_busy  out  1  fence not yet satisfied.
- empty  out  1  no pending entries.
- full  out  1  DEPTH pending entries.
- count  out  $clog2(DEPTH)+1  pending entry count.
- fwd_hits  out  CNT_W  saturating count of forwarded loads.

Behaviour:
- Reset (async assert, sync deassert at the next clk edge):
  - head, tail and count = 0; all entry valid bits = 0; fwd_hits = 0.
  - Outputs: empty=1, full=0, st_ready=1, mem_wr_valid=0, mem_wr_addr/data=0, ld_hit=0, ld_data=0, fence_busy=0.
  - Reset mid-operation discards pending stores; no memory write occurs for them.
- Storage: circular FIFO of {addr, data, valid}. Pointers wrap modulo DEPTH.
- Enqueue: on a clk edge with st_valid && st_ready, write entry[tail], set its valid bit, tail+1. Latency: the entry is visible on mem_wr_* and to forwarding from the next cycle.
- st_ready = !full && !fence_req. A full buffer never accepts a store, even in a cycle where it drains.
- Dequeue:
  - mem_wr_valid = !empty; mem_wr_addr/data come from entry[head], driven directly from registers.
  - On mem_wr_valid && mem_wr_ready: clear the valid bit, head+1.
  - While mem_wr_valid=1 and mem_wr_ready=0, mem_wr_addr/data hold stable.
- Simultaneous enqueue and dequeue: count unchanged, both pointers advance.
- count, empty and full are derived from the registered count only.
- Forwarding (combinational):
  - When ld_valid=1, compare ld_addr[ADDR_W-1:3] against the addr[ADDR_W-1:3] of every valid entry.
  - Pick the youngest match, searching from tail-1 back to head.
  - Drive ld_hit=1 and ld_data from that entry.
  - The low 3 address bits are ignored for matching; all accesses are doubleword.
  - An entry that is being dequeued in the current cycle still forwards.
  - A store being enqueued in the same cycle is not visible to a load in that cycle.
  - With ld_valid=0: ld_hit=0, ld_data=0.
- fwd_hits increments on each clk edge where ld_valid && ld_hit, and saturates at all-ones.
- Fence: fence_busy = fence_req && !empty. It drops combinationally in the first cycle that empty=1. Draining continues normally during a fence.

Decomposition:
- Package sb_pkg holds sb_entry_t (addr, data, valid), the DW_OFFSET=3 constant, and a function computing the pointer width from DEPTH.
- One sub-module: sb_fwd_match, a combinational youngest-first priority match. Inputs: the entry array, head, tail and load address. Outputs: hit and data.
- FIFO control and counters stay in store_buffer.

Test Plan:
- After reset: empty=1, st_ready=1, mem_wr_valid=0, fwd_hits=0. Then store 0x100<-0xAA with mem_wr_ready=1 -> next cycle mem_wr_valid=1, addr=0x100, data=0xAA, written the cycle after, then empty=1.
- Fill, with mem_wr_ready=0 and DEPTH=4:
  - Four stores to 0x0,0x8,0x10,0x18 -> full=1, st_ready=0; a fifth store is refused.
  - Raise mem_wr_ready -> drain order 0x0,0x8,0x10,0x18; a store offered while full-and-draining is still refused.
- Forwarding:
  - Stores 0x40<-1 then 0x40<-2 pending -> load 0x44 gives ld_hit=1, ld_data=2; fwd_hits increments by 1.
  - Load 0x48 -> ld_hit=0, ld_data=0.
- Same-cycle: store 0x80<-5 enqueued while a load of 0x80 is issued -> ld_hit=0. The same load repeated the next cycle -> ld_hit=1, ld_data=5.
- Fence: 3 pending entries, fence_req=1, mem_wr_ready toggling -> st_ready=0 and fence_busy=1 until the third handshake; fence_busy=0 in the cycle empty=1.
- Reset mid-drain: rst_n pulsed low with 2 entries pending and mem_wr_valid=1 -> mem_wr_valid=0 immediately (async), count=0, and no further writes are observed.

Source files
------------

// File: rtl/sb_pkg.sv
// Shared types and constants for the store buffer: entry layout, doubleword
// granularity and pointer sizing.
package sb_pkg;

    localparam int unsigned SB_ADDR_W = 32;
    localparam int unsigned SB_DATA_W = 64;
    localparam int unsigned DW_OFFSET = 3;

    // Clears the byte-within-doubleword bits so matches compare whole doublewords
    localparam logic [SB_ADDR_W-1:0] SB_DW_MASK = ~SB_ADDR_W'((1 << DW_OFFSET) - 1);

    typedef struct packed {
        logic [SB_ADDR_W-1:0] addr;
        logic [SB_DATA_W-1:0] data;
        logic                 valid;
    } sb_entry_t;

    function automatic int unsigned sb_ptr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sb_fwd_match.sv
// Youngest-first store-to-load forwarding match over the pending entries,
// walking from tail-1 back to head.
module sb_fwd_match
    import sb_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = sb_ptr_w(DEPTH)
) (
    input  sb_entry_t              i_entries [DEPTH],
    input  logic [PTR_W-1:0]       i_head,
    input  logic [PTR_W-1:0]       i_tail,
    input  logic [SB_ADDR_W-1:0]   i_ld_addr,
    output logic                   o_hit,
    output logic [SB_DATA_W-1:0]   o_data
);

    logic             w_done;
    logic [PTR_W-1:0] w_idx;

    // First valid doubleword match found walking backwards in age wins
    always_comb begin
        o_hit  = 1'b0;
        o_data = '0;
        w_done = 1'b0;
        w_idx  = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            w_idx = i_tail - PTR_W'(k + 1);
            if (!w_done && i_entries[w_idx].valid &&
                (((i_entries[w_idx].addr ^ i_ld_addr) & SB_DW_MASK) == '0)) begin
                o_hit  = 1'b1;
                o_data = i_entries[w_idx].data;
                w_done = 1'b1;
            end
            if (w_idx == i_head) begin
                w_done = 1'b1;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer: in-order drain to data memory over valid/ready,
// youngest-match load forwarding, fence status and a forward-hit counter.
module store_buffer
    import sb_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = SB_ADDR_W,
    parameter int unsigned DATA_W = SB_DATA_W,
    parameter int unsigned CNT_W  = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       st_valid,
    input  logic [ADDR_W-1:0]          st_addr,
    input  logic [DATA_W-1:0]          st_data,
    output logic                       st_ready,
    input  logic                       ld_valid,
    input  logic [ADDR_W-1:0]          ld_addr,
    output logic                       ld_hit,
    output logic [DATA_W-1:0]          ld_data,
    output logic                       mem_wr_valid,
    output logic [ADDR_W-1:0]          mem_wr_addr,
    output logic [DATA_W-1:0]          mem_wr_data,
    input  logic                       mem_wr_ready,
    input  logic                       fence_req,
    output logic                       fence_busy,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count,
    output logic [CNT_W-1:0]           fwd_hits
);

    localparam int unsigned PTR_W    = sb_ptr_w(DEPTH);
    localparam int unsigned CNT_BITS = $clog2(DEPTH) + 1;

    // Entry layout is fixed by the package; reject mismatched overrides early
    if (ADDR_W != SB_ADDR_W || DATA_W != SB_DATA_W) begin : g_bad_width
        $error("store_buffer: ADDR_W/DATA_W must match sb_pkg entry widths");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("store_buffer: DEPTH must be a power of two, at least 2");
    end

    sb_entry_t           r_entries [DEPTH];
    logic [PTR_W-1:0]    r_head;
    logic [PTR_W-1:0]    r_tail;
    logic [CNT_BITS-1:0] r_count;
    logic [CNT_W-1:0]    r_fwd_hits;

    logic                w_empty;
    logic                w_full;
    logic                w_push;
    logic                w_pop;
    logic                w_hit;
    logic [DATA_W-1:0]   w_fwd_data;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_BITS'(DEPTH));
    assign w_push  = st_valid && st_ready;
    assign w_pop   = mem_wr_valid && mem_wr_ready;

    assign st_ready     = !w_full && !fence_req;
    assign empty        = w_empty;
    assign full         = w_full;
    assign count        = r_count;
    assign fence_busy   = fence_req && !w_empty;
    assign mem_wr_valid = !w_empty;
    assign mem_wr_addr  = r_entries[r_head].addr;
    assign mem_wr_data  = r_entries[r_head].data;
    assign fwd_hits     = r_fwd_hits;

    sb_fwd_match #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fwd_match (
        .i_entries (r_entries),
        .i_head    (r_head),
        .i_tail    (r_tail),
        .i_ld_addr (ld_addr),
        .o_hit     (w_hit),
        .o_data    (w_fwd_data)
    );

    assign ld_hit  = ld_valid && w_hit;
    assign ld_data = ld_hit ? w_fwd_data : '0;

    // Entry storage; head and tail only coincide when empty or full, so a
    // push and a pop in the same cycle always touch different entries
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_entries[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_entries[r_tail] <= '{addr: st_addr, data: st_data, valid: 1'b1};
            end
            if (w_pop) begin
                r_entries[r_head].valid <= 1'b0;
            end
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_BITS'(1);
                2'b01:   r_count <= r_count - CNT_BITS'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Saturating forwarded-load counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fwd_hits <= '0;
        end else if (ld_hit && (r_fwd_hits != '1)) begin
            r_fwd_hits <= r_fwd_hits + CNT_W'(1);
        end
    end

endmodule
